// File: rtl/axi_wr_router.sv
// -----------------------------------------------------------------------------
// axi_wr_router
//
// Write-side address router that sits behind the AXI-to-BRAM write bridge.
// The early burst address picks one of four targets:
//   BRAM port, 32-bit command FIFO, eight control registers, or nothing.
// Single-word writes are then steered by the registered select.
// dev_ready throttles the bridge when the command FIFO is nearly full.
//
// Parameters
//   ADDRESS_BITS    word-address width of the bridge (>= 6)
//   FIFO_DEPTH_BITS log2 of the command FIFO depth
//
// Ports
//   aclk, rst                  clock, async active-high reset
//   pre_awaddr, start_burst    early burst address and its qualifier
//   dev_ready                  combinatorial ready back to the bridge
//   wen, waddr, wstb, wdata    single-word write
//   mem_*                      BRAM write port (combinatorial)
//   cmd_data, cmd_valid        command FIFO head
//   cmd_ready                  command FIFO pop
//   ctrl_regs, ctrl_wr         control registers and per-register write pulse
//   fifo_ovf, ovf_clr          sticky FIFO overflow flag and its clear
//   unmapped_cnt               saturating unmapped-write counter
//
// Optional feature macro: AXI_WR_ROUTER_ERRCNT_EN adds the unmapped_cnt port.
// -----------------------------------------------------------------------------
module axi_wr_router #(
    parameter int ADDRESS_BITS    = 10,
    parameter int FIFO_DEPTH_BITS = 4
) (
    input  logic                    aclk,
    input  logic                    rst,
    input  logic [ADDRESS_BITS-1:0] pre_awaddr,
    input  logic                    start_burst,
    output logic                    dev_ready,
    input  logic                    wen,
    input  logic [ADDRESS_BITS-1:0] waddr,
    input  logic [3:0]              wstb,
    input  logic [31:0]             wdata,
    output logic [ADDRESS_BITS-2:0] mem_waddr,
    output logic                    mem_wen,
    output logic [3:0]              mem_wstb,
    output logic [31:0]             mem_wdata,
    output logic [31:0]             cmd_data,
    output logic                    cmd_valid,
    input  logic                    cmd_ready,
    output logic [255:0]            ctrl_regs,
    output logic [7:0]              ctrl_wr,
    output logic                    fifo_ovf,
`ifdef AXI_WR_ROUTER_ERRCNT_EN
    output logic [15:0]             unmapped_cnt,
`endif
    input  logic                    ovf_clr
);

    localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
    localparam int CNT_W = FIFO_DEPTH_BITS + 1;
    localparam logic [FIFO_DEPTH_BITS-1:0] PTR_INC   = FIFO_DEPTH_BITS'(1);
    localparam logic [CNT_W-1:0]           CNT_INC   = CNT_W'(1);
    localparam logic [CNT_W-1:0]           CNT_FULL  = CNT_W'(DEPTH);
    // Two writes may still land after dev_ready drops (bridge registers it).
    localparam logic [CNT_W-1:0]           CNT_LIMIT = CNT_W'(DEPTH - 3);

    typedef enum logic [1:0] {
        SEL_MEM  = 2'd0,
        SEL_CMD  = 2'd1,
        SEL_REG  = 2'd2,
        SEL_NONE = 2'd3
    } sel_t;

    function automatic sel_t dec(input logic [ADDRESS_BITS-1:0] a);
        sel_t s;
        if (!a[ADDRESS_BITS-1])
            s = SEL_MEM;
        else if (!a[ADDRESS_BITS-2])
            s = SEL_CMD;
        else if (a[ADDRESS_BITS-3:3] == '0)
            s = SEL_REG;
        else
            s = SEL_NONE;
        return s;
    endfunction

    sel_t sel_r;
    sel_t sel_next;

    logic [31:0]                fifo_mem [DEPTH];
    logic [FIFO_DEPTH_BITS-1:0] wr_ptr;
    logic [FIFO_DEPTH_BITS-1:0] rd_ptr;
    logic [CNT_W-1:0]           fifo_cnt;
    logic                       fifo_full;
    logic                       cmd_room;
    logic                       push;
    logic                       pop;
    logic                       push_ok;

    logic [31:0] regs [8];
    logic        reg_wr;

    // Address bits that no decode or routing path needs.
    logic unused_bits;
    assign unused_bits = ^{pre_awaddr[2:0], waddr[ADDRESS_BITS-1]};

    // ---------------------------------------------------------------- select
    assign sel_next = dec(pre_awaddr);

    always_ff @(posedge aclk or posedge rst) begin
        if (rst)
            sel_r <= SEL_MEM;
        else if (start_burst)
            sel_r <= sel_next;
    end

    assign fifo_full = (fifo_cnt == CNT_FULL);
    assign cmd_room  = (fifo_cnt <= CNT_LIMIT);

    // The queued burst may throttle the current one; the FIFO drain unblocks it.
    assign dev_ready = ((sel_r != SEL_CMD) || cmd_room) &&
                       ((sel_next != SEL_CMD) || cmd_room);

    // ------------------------------------------------------------------ BRAM
    assign mem_wen   = wen && (sel_r == SEL_MEM);
    assign mem_waddr = waddr[ADDRESS_BITS-2:0];
    assign mem_wstb  = wstb;
    assign mem_wdata = wdata;

    // ------------------------------------------------------------------ FIFO
    assign push      = wen && (sel_r == SEL_CMD);
    assign cmd_valid = (fifo_cnt != '0);
    assign pop       = cmd_ready && cmd_valid;
    // A full FIFO still takes a push when the same cycle frees a slot.
    assign push_ok   = push && (!fifo_full || pop);
    assign cmd_data  = fifo_mem[rd_ptr];

    always_ff @(posedge aclk) begin
        if (push_ok)
            fifo_mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            fifo_ovf <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + PTR_INC;
            if (pop)
                rd_ptr <= rd_ptr + PTR_INC;
            case ({push_ok, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_INC;
                2'b01:   fifo_cnt <= fifo_cnt - CNT_INC;
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (ovf_clr)
                fifo_ovf <= 1'b0;
            else if (push && !push_ok)
                fifo_ovf <= 1'b1;
        end
    end

    // ------------------------------------------------------------- registers
    assign reg_wr = wen && (sel_r == SEL_REG);

    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++)
                regs[i] <= '0;
            ctrl_wr <= '0;
        end else begin
            if (reg_wr) begin
                for (int b = 0; b < 4; b++)
                    if (wstb[b])
                        regs[waddr[2:0]][8*b +: 8] <= wdata[8*b +: 8];
                ctrl_wr <= 8'b1 << waddr[2:0];
            end else begin
                ctrl_wr <= '0;
            end
        end
    end

    always_comb begin
        ctrl_regs = '0;
        for (int i = 0; i < 8; i++)
            ctrl_regs[32*i +: 32] = regs[i];
    end

    // ------------------------------------------------------- unmapped count
`ifdef AXI_WR_ROUTER_ERRCNT_EN
    always_ff @(posedge aclk or posedge rst) begin
        if (rst)
            unmapped_cnt <= '0;
        else if (wen && (sel_r == SEL_NONE) && (unmapped_cnt != 16'hFFFF))
            unmapped_cnt <= unmapped_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_axi_wr_router.sv
module tb_axi_wr_router;

    logic         aclk = 1'b0;
    logic         rst;
    logic [9:0]   pre_awaddr;
    logic         start_burst;
    logic         dev_ready;
    logic         wen;
    logic [9:0]   waddr;
    logic [3:0]   wstb;
    logic [31:0]  wdata;
    logic [8:0]   mem_waddr;
    logic         mem_wen;
    logic [3:0]   mem_wstb;
    logic [31:0]  mem_wdata;
    logic [31:0]  cmd_data;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [255:0] ctrl_regs;
    logic [7:0]   ctrl_wr;
    logic         fifo_ovf;
    logic         ovf_clr;
`ifdef AXI_WR_ROUTER_ERRCNT_EN
    logic [15:0]  unmapped_cnt;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    axi_wr_router #(.ADDRESS_BITS(10), .FIFO_DEPTH_BITS(4)) dut (
        .aclk        (aclk),
        .rst         (rst),
        .pre_awaddr  (pre_awaddr),
        .start_burst (start_burst),
        .dev_ready   (dev_ready),
        .wen         (wen),
        .waddr       (waddr),
        .wstb        (wstb),
        .wdata       (wdata),
        .mem_waddr   (mem_waddr),
        .mem_wen     (mem_wen),
        .mem_wstb    (mem_wstb),
        .mem_wdata   (mem_wdata),
        .cmd_data    (cmd_data),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .ctrl_regs   (ctrl_regs),
        .ctrl_wr     (ctrl_wr),
        .fifo_ovf    (fifo_ovf),
`ifdef AXI_WR_ROUTER_ERRCNT_EN
        .unmapped_cnt(unmapped_cnt),
`endif
        .ovf_clr     (ovf_clr)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic burst(input logic [9:0] a);
        start_burst = 1'b1;
        pre_awaddr  = a;
        tick();
        start_burst = 1'b0;
    endtask

    int n;
    int cnt_model;
    int pops;
    logic dr_q;
    logic dr_next;

    initial begin
        rst = 1'b1; pre_awaddr = '0; start_burst = 0; wen = 0; waddr = '0;
        wstb = '0; wdata = '0; cmd_ready = 0; ovf_clr = 0;
        repeat (2) @(posedge aclk);
        #1;
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_ctrl_regs", |ctrl_regs, 0);
        check("rst_ctrl_wr", ctrl_wr, 0);
        check("rst_fifo_ovf", fifo_ovf, 0);
        check("rst_dev_ready", dev_ready, 1);
`ifdef AXI_WR_ROUTER_ERRCNT_EN
        check("rst_unmapped", unmapped_cnt, 0);
`endif
        rst = 1'b0;
        tick();

        // BRAM burst
        burst(10'h010);
        for (int i = 0; i < 4; i++) begin
            wen = 1; waddr = 10'h010 + 10'(i); wstb = 4'hF; wdata = 32'h1000 + i;
            #1;
            check("mem_wen", mem_wen, 1);
            check("mem_waddr", mem_waddr, 9'h010 + 9'(i));
            check("mem_wdata", mem_wdata, 32'h1000 + i);
            tick();
        end
        wen = 0;
        #1;
        check("mem_wen_idle", mem_wen, 0);
        check("bram_cmd_valid", cmd_valid, 0);

        // Register write with partial strobes
        burst(10'h305);
        wen = 1; waddr = 10'h305; wstb = 4'b0101; wdata = 32'hAABBCCDD;
        #1;
        check("reg_mem_wen", mem_wen, 0);
        tick();
        wen = 0;
        check("reg5_value", ctrl_regs[5*32 +: 32], 32'h00BB00DD);
        check("reg_ctrl_wr", ctrl_wr, 8'h20);
        tick();
        check("reg_ctrl_wr_end", ctrl_wr, 8'h00);

        // Back-to-back bursts: write coincident with start_burst uses old select
        burst(10'h010);
        start_burst = 1; pre_awaddr = 10'h200;
        wen = 1; waddr = 10'h011; wstb = 4'hF; wdata = 32'h55;
        #1;
        check("b2b_old_mem_wen", mem_wen, 1);
        tick();
        start_burst = 0;
        waddr = 10'h200; wdata = 32'h12345678;
        #1;
        check("b2b_new_mem_wen", mem_wen, 0);
        tick();
        wen = 0;
        check("b2b_cmd_valid", cmd_valid, 1);
        check("b2b_cmd_data", cmd_data, 32'h12345678);
        cmd_ready = 1;
        tick();
        cmd_ready = 0;
        check("b2b_popped", cmd_valid, 0);

        // FIFO fill with a bridge that honours registered dev_ready
        burst(10'h200);
        dr_q = 1; n = 0; cnt_model = 0;
        for (int c = 0; c < 30; c++) begin
            wen = dr_q && (n < 16);
            waddr = 10'h200 + 10'(n); wstb = 4'h0; wdata = 32'hC000_0000 + n;
            #1;
            check("fill_dev_ready", dev_ready, (cnt_model <= 13) ? 1 : 0);
            dr_next = dev_ready;
            tick();
            if (wen) begin
                n++;
                cnt_model++;
            end
            dr_q = dr_next;
        end
        wen = 0;
        check("fill_stored", n, 15);
        check("fill_ovf", fifo_ovf, 0);
        cmd_ready = 1;
        for (int i = 0; i < 15; i++) begin
            check("drain_valid", cmd_valid, 1);
            check("drain_data", cmd_data, 32'hC000_0000 + i);
            tick();
        end
        check("drain_empty", cmd_valid, 0);
        cmd_ready = 0;

        // Forced overflow
        for (int i = 0; i < 17; i++) begin
            wen = 1; wdata = 32'hD000_0000 + i;
            if (i == 16) check("ovf_before", fifo_ovf, 0);
            tick();
        end
        check("ovf_set", fifo_ovf, 1);
        check("ovf_head", cmd_data, 32'hD000_0000);
        ovf_clr = 1; wdata = 32'hDEAD;
        tick();
        ovf_clr = 0;
        check("ovf_clr_priority", fifo_ovf, 0);
        tick();
        wen = 0;
        check("ovf_reset_again", fifo_ovf, 1);
        cmd_ready = 1; pops = 0;
        for (int i = 0; i < 20; i++) begin
            if (cmd_valid) pops++;
            tick();
        end
        cmd_ready = 0;
        check("ovf_occupancy", pops, 16);
        ovf_clr = 1;
        tick();
        ovf_clr = 0;

        // Unmapped region
        burst(10'h308);
        for (int i = 0; i < 3; i++) begin
            wen = 1; waddr = 10'h308 + 10'(i); wstb = 4'hF; wdata = 32'hFFFF_FFFF;
            #1;
            check("unm_mem_wen", mem_wen, 0);
            tick();
            check("unm_ctrl_wr", ctrl_wr, 0);
        end
        wen = 0;
        check("unm_cmd_valid", cmd_valid, 0);
        check("unm_reg0", ctrl_regs[31:0], 0);
        check("unm_reg1", ctrl_regs[63:32], 0);
`ifdef AXI_WR_ROUTER_ERRCNT_EN
        check("unm_count", unmapped_cnt, 3);
`endif

        // Reset mid-burst with a nearly full FIFO
        burst(10'h200);
        for (int i = 0; i < 14; i++) begin
            wen = 1; wdata = 32'hE000_0000 + i;
            tick();
        end
        wen = 0;
        check("pre_rst_dev_ready", dev_ready, 0);
        #3 rst = 1;
        #1;
        check("rst_mid_dev_ready", dev_ready, 1);
        check("rst_mid_cmd_valid", cmd_valid, 0);
        check("rst_mid_reg5", ctrl_regs[5*32 +: 32], 0);
`ifdef AXI_WR_ROUTER_ERRCNT_EN
        check("rst_mid_unmapped", unmapped_cnt, 0);
`endif
        rst = 0;
        tick();
        wen = 1; waddr = 10'h020; pre_awaddr = 10'h000;
        #1;
        check("rst_sel_mem", mem_wen, 1);
        tick();
        wen = 0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
